uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL declare parameter CLK_HZ, default 21477272, meaning system clock frequency in Hz.
REQ-002 SHALL declare parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idle high, 8 data bits, LSB first.
REQ-006 SHALL have port out_data  output  8  last received byte; feeds the ROM loader byte input.
REQ-007 SHALL have port out_valid  output  1  one-cycle strobe: out_data holds a new byte; feeds the loader byte strobe.
REQ-008 SHALL have port frame_err  output  1  one-cycle strobe: stop bit (or parity) check failed.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer reset to 1; all sampling uses the synchronized value (rx_s).
REQ-011 SHALL use bit period DIV = (CLK_HZ + BAUD/2) / BAUD (integer, rounded); counter width = clog2(DIV)+1.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-013 IDLE: on rx_s == 0 load counter with DIV/2 - 1 and go to START.
REQ-014 START: at counter 0 sample rx_s; if 1 (glitch) return to IDLE, no strobe; if 0 load DIV-1, clear bit index, go to DATA.
REQ-015 DATA: at each counter 0 shift rx_s into bit[index] (LSB first), reload DIV-1; after index 7 go to STOP (or PARITY).
REQ-016 STOP: at counter 0 sample rx_s; if 1, update out_data, pulse out_valid on the next cycle, go to IDLE; if 0, pulse frame_err, leave out_data unchanged, go to BREAK.
REQ-017 BREAK: remain until rx_s == 1, then go to IDLE; a low line is never treated as a new start bit.
REQ-018 Returning to IDLE at mid-stop-bit SHALL let a start bit immediately following the stop bit (zero idle time) be received correctly.
REQ-019 out_valid and frame_err SHALL never be high for more than one consecutive cycle and SHALL never both be high.
REQ-020 Latency: out_valid SHALL assert exactly 1 cycle after the mid-stop-bit sample cycle.

Reset
REQ-021 Reset SHALL force state IDLE, out_data 0x00, out_valid 0, frame_err 0, busy 0, counter 0, synchronizer flops 1.
REQ-022 Reset mid-byte SHALL discard the partial byte with no strobe; reception restarts on the next falling edge after reset deasserts.

Configuration
REQ-023 Macro UART_RX_PARITY_EN SHALL, when defined, insert a PARITY state after DATA sampling one even-parity bit at mid-bit (frame 8E1).
REQ-024 With UART_RX_PARITY_EN, a parity mismatch SHALL be latched; at STOP a mismatch SHALL pulse frame_err instead of out_valid (then IDLE if stop=1, BREAK if stop=0).
REQ-025 Without UART_RX_PARITY_EN the frame SHALL be 8N1 and no parity logic SHALL exist.

Verification (CLK_HZ=16, BAUD=1, DIV=16)
REQ-026 Send 0x4E in 8N1 -> out_valid for exactly one cycle, out_data=0x4E, 1 cycle after the mid-stop sample; frame_err stays 0.
REQ-027 Drive rx low for 5 cycles, then high -> START rejects it, no out_valid, no frame_err, busy back to 0 within 9 cycles.
REQ-028 Send 0x45 then 0x53 with zero idle bits -> two out_valid pulses, 160 cycles apart, data 0x45 then 0x53.
REQ-029 Send 0xA5 with stop bit 0 and hold rx low 40 cycles -> one frame_err pulse, no out_valid, out_data unchanged, state BREAK until rx high.
REQ-030 Assert reset during bit 4 of 0x1A, then send 0x1A -> no strobe from the partial byte; the second byte yields out_data=0x1A.
REQ-031 With UART_RX_PARITY_EN, send 0x4E with parity 1 (wrong; even parity is 0) -> frame_err pulse, no out_valid; with parity 0 -> out_valid, out_data=0x4E.

Source files
------------

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: serial line in, received byte / strobes / busy out
interface uart_byte_rx_if;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       busy;
    modport master (output rx, input out_data, out_valid, frame_err, busy);
    modport slave  (input rx, output out_data, out_valid, frame_err, busy);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 (or 8E1 with UART_RX_PARITY_EN) UART byte receiver
//   clk            rising-edge system clock
//   reset          synchronous active-high reset
//   bus.rx         async serial line, idle high, LSB first
//   bus.out_data   last good byte
//   bus.out_valid  one-cycle strobe, out_data holds a new byte
//   bus.frame_err  one-cycle strobe, stop (or parity) check failed
//   bus.busy       receiver not idle
module uart_byte_rx #(
    parameter int CLK_HZ = 21477272,
    parameter int BAUD   = 115200
) (
    input logic       clk,
    input logic       reset,
    uart_byte_rx_if.slave bus
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV) + 1;
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP, BREAK
    } state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg, out_data_r;
    logic out_valid_r, frame_err_r, rx_m, rx_s, tick, perr;
`ifdef UART_RX_PARITY_EN
    logic par_err;
    assign perr = par_err;
`else
    assign perr = 1'b0;
`endif
    assign tick = cnt == '0;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_err     <= 1'b0;
`endif
        end else begin
            rx_m        <= bus.rx;
            rx_s        <= rx_m;
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            if (state != IDLE && state != BREAK && !tick)
                cnt <= cnt - 1'b1;
            case (state)
                IDLE: if (!rx_s) begin
                    cnt   <= HALF;
                    state <= START;
                end
                START: if (tick) begin
                    if (rx_s) state <= IDLE;
                    else begin
                        cnt   <= FULL;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: if (tick) begin
                    shreg[idx] <= rx_s;
                    cnt        <= FULL;
                    idx        <= idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (idx == 3'd7) state <= PARITY;
`else
                    if (idx == 3'd7) state <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    par_err <= rx_s != ^shreg;
                    cnt     <= FULL;
                    state   <= STOP;
                end
`endif
                STOP: if (tick) begin
                    // returning to IDLE at mid-stop lets a back-to-back start bit be caught
                    if (rx_s && !perr) begin
                        out_data_r  <= shreg;
                        out_valid_r <= 1'b1;
                    end else
                        frame_err_r <= 1'b1;
                    state <= rx_s ? IDLE : BREAK;
                end
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: randomized frames checked against a frame-timing model
module tb_uart_byte_rx;
    localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 10;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 9;
    localparam bit PAR = 1'b0;
`endif
    // strobe cycle after the start edge: 2 sync flops + 1 detect, half bit, then NB full bits
    localparam int LAT = 3 + DIV / 2 + DIV * NB;
    logic clk = 1'b0;
    logic reset = 1'b1;
    uart_byte_rx_if u_if ();
    uart_byte_rx #(.CLK_HZ(16), .BAUD(1)) dut (.clk(clk), .reset(reset), .bus(u_if));
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_pass = 0, n_tot = 0;
    bit chk_on = 1'b0, rst_pend = 1'b0;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] exp_v[int];
    bit exp_f[int];
    int vq[$];
    int fq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    always @(negedge clk) if (chk_on) begin
        bit ev_v, ev_f;
        if (rst_pend) last_byte = 8'h00;
        rst_pend = reset;
        ev_v = exp_v.exists(cyc);
        ev_f = exp_f.exists(cyc);
        if (ev_v) last_byte = exp_v[cyc];
        chk("out_valid", u_if.out_valid, ev_v);
        chk("frame_err", u_if.frame_err, ev_f);
        chk("out_data", u_if.out_data, last_byte);
        if (u_if.out_valid) vq.push_back(cyc);
        if (u_if.frame_err) fq.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        u_if.rx = v;
        step(DIV);
    endtask

    task automatic idle(input int n);
        u_if.rx = 1'b1;
        step(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
        int ev;
        ev = cyc + LAT;
        if (!stop_b || (PAR && par_b != ^b)) exp_f[ev] = 1'b1;
        else exp_v[ev] = b;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR) drive_bit(par_b);
        drive_bit(stop_b);
    endtask

    initial begin
        int t0, n, f;
        logic [7:0] b;
        logic p;
        u_if.rx = 1'b1;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        chk("rst_out_valid", u_if.out_valid, 1'b0);
        chk("rst_frame_err", u_if.frame_err, 1'b0);
        chk("rst_busy", u_if.busy, 1'b0);
        chk("rst_out_data", u_if.out_data, 8'h00);
        chk_on = 1'b1;
        step(2);
        t0 = cyc;
        send_frame(8'h4E, 1'b1, 1'b0);
        idle(20);
        chk("lat_4e", vq.size() > 0 ? vq[0] - t0 : -1, PAR ? 171 : 155);
        chk("data_4e", u_if.out_data, 8'h4E);
        chk("ferr_cnt_4e", fq.size(), 0);
`ifdef UART_RX_PARITY_EN
        send_frame(8'h4E, 1'b1, 1'b1);
        idle(20);
        chk("par_bad_ferr", fq.size(), 1);
        chk("par_bad_valid", vq.size(), 1);
        send_frame(8'h4E, 1'b1, 1'b0);
        idle(20);
        chk("par_ok_valid", vq.size(), 2);
`endif
        n = vq.size();
        f = fq.size();
        u_if.rx = 1'b0;
        step(5);
        chk("glitch_busy_hi", u_if.busy, 1'b1);
        u_if.rx = 1'b1;
        step(9);
        chk("glitch_busy_lo", u_if.busy, 1'b0);
        chk("glitch_no_valid", vq.size(), n);
        chk("glitch_no_ferr", fq.size(), f);
        send_frame(8'h45, 1'b1, ^8'h45);
        send_frame(8'h53, 1'b1, ^8'h53);
        idle(20);
        chk("b2b_count", vq.size(), n + 2);
        chk("b2b_spacing", vq.size() == n + 2 ? vq[n+1] - vq[n] : -1, PAR ? 176 : 160);
        chk("b2b_data", u_if.out_data, 8'h53);
        n = vq.size();
        f = fq.size();
        send_frame(8'hA5, 1'b0, ^8'hA5);
        u_if.rx = 1'b0;
        step(40);
        chk("break_busy", u_if.busy, 1'b1);
        chk("break_ferr", fq.size(), f + 1);
        idle(4);
        chk("break_exit", u_if.busy, 1'b0);
        chk("break_data", u_if.out_data, 8'h53);
        chk("break_no_valid", vq.size(), n);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h1A >> i));
        u_if.rx = 1'b1;
        step(5);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        idle(20);
        chk("rst_mid_no_valid", vq.size(), n);
        chk("rst_mid_busy", u_if.busy, 1'b0);
        chk("rst_mid_data", u_if.out_data, 8'h00);
        send_frame(8'h1A, 1'b1, ^8'h1A);
        idle(20);
        chk("after_rst_data", u_if.out_data, 8'h1A);
        repeat (20) begin
            b = 8'($urandom);
            p = ^b;
            if (PAR && $urandom_range(0, 4) == 0) p = ~p;
            send_frame(b, 1'b1, p);
            idle($urandom_range(0, 20));
        end
        idle(200);
        chk("leftover_none", vq.size() + fq.size() <= 64, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
